// File: rtl/trap_controller.sv
// Trap controller: prioritises exceptions, interrupts and MRET, then runs
// a stall -> flush pulse -> fetch-redirect handshake. Optional interrupt
// path is enabled by defining TRAP_INTERRUPT_EN.
module trap_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        decodeIllegal,
  input  logic        decodeEcall,
  input  logic        decodeEbreak,
  input  logic        executeMisalign,
  input  logic        memoryLoadMisalign,
  input  logic        memoryStoreMisalign,
  input  logic        mretRequest,
  input  logic [31:0] mepc,
  input  logic [31:0] trapVector,
  input  logic        interrupt,
  input  logic        mie,
  output logic        stall,
  output logic        controlReset,
  output logic [3:0]  mcause,
  output logic        mcauseInterrupt,
  output logic        redirectValid,
  output logic [31:0] redirectPC,
  input  logic        redirectReady
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  typedef struct packed {
    logic [3:0]  cause;
    logic        intr;
    logic [31:0] target;
  } trap_t;

  state_t      state, stateNext;
  trap_t       src, lat;
  logic        srcValid, srcMret, irqPending;
  logic [15:0] trapCount;

`ifdef TRAP_INTERRUPT_EN
  // Interrupt is asynchronous to clock; two flops before it is trusted.
  logic [1:0] irqSync;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) irqSync <= '0;
    else        irqSync <= {irqSync[0], interrupt};
  end
  assign irqPending = irqSync[1] & mie;
`else
  logic unused_irq;
  assign unused_irq = interrupt ^ mie;
  assign irqPending = 1'b0;
`endif

  // Fixed-priority source select, oldest pipeline stage first.
  always_comb begin
    srcValid   = 1'b1;
    srcMret    = 1'b0;
    src.cause  = 4'h0;
    src.intr   = 1'b0;
    src.target = trapVector;
    if (memoryStoreMisalign)      src.cause = 4'h6;
    else if (memoryLoadMisalign)  src.cause = 4'h4;
    else if (executeMisalign)     src.cause = 4'h0;
    else if (decodeIllegal)       src.cause = 4'h2;
    else if (decodeEbreak)        src.cause = 4'h3;
    else if (decodeEcall)         src.cause = 4'hB;
    else if (irqPending) begin
      src.cause = 4'hB;
      src.intr  = 1'b1;
    end else if (mretRequest) begin
      srcMret    = 1'b1;
      src.target = mepc;
    end else begin
      srcValid   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (srcValid) stateNext = FLUSH;
      FLUSH:    stateNext = REDIRECT;
      REDIRECT: if (redirectReady) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // Cause/target captured only on IDLE exit, so later sources are dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat       <= '0;
      trapCount <= '0;
    end else if (state == IDLE && srcValid) begin
      lat <= src;
      if (!srcMret && trapCount != 16'hFFFF) trapCount <= trapCount + 16'd1;
    end
  end

  assign stall           = (reset && state == IDLE && srcValid) || state == FLUSH;
  assign controlReset    = (state == FLUSH);
  assign mcause          = (state == FLUSH) ? lat.cause : 4'h0;
  assign mcauseInterrupt = (state == FLUSH) & lat.intr;
  assign redirectValid   = (state == REDIRECT);
  assign redirectPC      = (state == REDIRECT) ? lat.target : 32'h0;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: expected trap results are queued at
// stimulus time and popped when the flush pulse appears.
module tb_trap_controller;

  logic        clock = 1'b0, reset = 1'b0;
  logic        decodeIllegal = 0, decodeEcall = 0, decodeEbreak = 0;
  logic        executeMisalign = 0, memoryLoadMisalign = 0, memoryStoreMisalign = 0;
  logic        mretRequest = 0, interrupt = 0, mie = 0, redirectReady = 0;
  logic [31:0] mepc = '0, trapVector = '0;
  logic        stall, controlReset, mcauseInterrupt, redirectValid;
  logic [3:0]  mcause;
  logic [31:0] redirectPC;

  int checks = 0, errors = 0;
  int crCount = 0, rvCount = 0;

  typedef struct {
    logic [3:0]  cause;
    logic        intr;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  trap_controller dut (
    .clock(clock), .reset(reset),
    .decodeIllegal(decodeIllegal), .decodeEcall(decodeEcall), .decodeEbreak(decodeEbreak),
    .executeMisalign(executeMisalign), .memoryLoadMisalign(memoryLoadMisalign),
    .memoryStoreMisalign(memoryStoreMisalign), .mretRequest(mretRequest),
    .mepc(mepc), .trapVector(trapVector), .interrupt(interrupt), .mie(mie),
    .stall(stall), .controlReset(controlReset), .mcause(mcause),
    .mcauseInterrupt(mcauseInterrupt), .redirectValid(redirectValid),
    .redirectPC(redirectPC), .redirectReady(redirectReady)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (controlReset === 1'b1) crCount++;
    if (redirectValid === 1'b1) rvCount++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_src();
    decodeIllegal = 0; decodeEcall = 0; decodeEbreak = 0;
    executeMisalign = 0; memoryLoadMisalign = 0; memoryStoreMisalign = 0;
    mretRequest = 0; interrupt = 0;
  endtask

  // Wait (bounded) for the flush pulse, then check it and the first redirect cycle.
  task automatic expect_trap(input string tag, input int lat);
    int   n;
    exp_t e;
    n = 0;
    while (controlReset !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_cr"}, controlReset, 1);
    chk({tag, "_lat"}, n, lat);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_mcause"}, mcause, e.cause);
    chk({tag, "_mint"}, mcauseInterrupt, e.intr);
    chk({tag, "_stall_f"}, stall, 1);
    tick();
    chk({tag, "_cr_once"}, controlReset, 0);
    chk({tag, "_rv"}, redirectValid, 1);
    chk({tag, "_pc"}, redirectPC, e.pc);
    chk({tag, "_stall_r"}, stall, 0);
  endtask

  // Holds redirectReady low for nHeld cycles total, then accepts.
  task automatic finish_redirect(input string tag, input int nHeld, input logic [31:0] pc);
    repeat (nHeld - 1) begin
      tick();
      chk({tag, "_hold_rv"}, redirectValid, 1);
      chk({tag, "_hold_pc"}, redirectPC, pc);
      chk({tag, "_hold_cr"}, controlReset, 0);
    end
    tick();
    clear_src();
    redirectReady = 1;
    #1;
    chk({tag, "_acc_pc"}, redirectPC, pc);
    tick();
    redirectReady = 0;
    #1;
    chk({tag, "_idle_rv"}, redirectValid, 0);
    chk({tag, "_idle_cr"}, controlReset, 0);
  endtask

  logic [5:0]  prioSrc  [6];
  logic        prioMret [6];
  logic [3:0]  prioCause[6];

  initial begin
    int cr0, rv0, tc0;

    // Reset state
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_cr", controlReset, 0);
    chk("rst_mcause", mcause, 0);
    chk("rst_mint", mcauseInterrupt, 0);
    chk("rst_rv", redirectValid, 0);
    chk("rst_pc", redirectPC, 0);
    chk("rst_tc", dut.trapCount, 0);
    tick();
    reset = 1;
    tick(); tick();

    // Illegal instruction, single-cycle assertion
    trapVector = 32'h0000_0100;
    decodeIllegal = 1;
    sb.push_back('{4'h2, 1'b0, 32'h0000_0100});
    #1;
    chk("ill_stall_T", stall, 1);
    tick();
    clear_src();
    trapVector = 32'hDEAD_0000;
    expect_trap("ill", 0);
    finish_redirect("ill", 1, 32'h0000_0100);
    chk("ill_tc", dut.trapCount, 1);

    // Store misalign beats ecall; exactly one flush pulse
    trapVector = 32'h0000_0200;
    cr0 = crCount;
    memoryStoreMisalign = 1; decodeEcall = 1;
    sb.push_back('{4'h6, 1'b0, 32'h0000_0200});
    tick();
    clear_src();
    expect_trap("st", 0);
    finish_redirect("st", 1, 32'h0000_0200);
    tick(); tick();
    chk("st_pulses", crCount - cr0, 1);

    // Back-pressured redirect with new sources arriving in FLUSH/REDIRECT
    trapVector = 32'h0000_0300;
    cr0 = crCount; rv0 = rvCount;
    decodeEcall = 1;
    sb.push_back('{4'hB, 1'b0, 32'h0000_0300});
    tick();
    clear_src();
    decodeIllegal = 1;
    expect_trap("bp", 0);
    decodeIllegal = 0;
    executeMisalign = 1;
    finish_redirect("bp", 3, 32'h0000_0300);
    tick(); tick();
    chk("bp_pulses", crCount - cr0, 1);
    chk("bp_rv_cycles", rvCount - rv0, 4);
    chk("bp_tc", dut.trapCount, 3);

    // MRET redirects to mepc without counting
    tc0 = dut.trapCount;
    mepc = 32'h8000_0040;
    mretRequest = 1;
    sb.push_back('{4'h0, 1'b0, 32'h8000_0040});
    #1;
    chk("mret_stall_T", stall, 1);
    tick();
    clear_src();
    mepc = 32'h0;
    expect_trap("mret", 0);
    finish_redirect("mret", 1, 32'h8000_0040);
    chk("mret_tc", dut.trapCount, tc0);

    // Priority table: {store,load,exec,illegal,ebreak,ecall}
    prioSrc[0] = 6'b011100; prioMret[0] = 0; prioCause[0] = 4'h4;
    prioSrc[1] = 6'b001010; prioMret[1] = 0; prioCause[1] = 4'h0;
    prioSrc[2] = 6'b000111; prioMret[2] = 0; prioCause[2] = 4'h2;
    prioSrc[3] = 6'b000011; prioMret[3] = 0; prioCause[3] = 4'h3;
    prioSrc[4] = 6'b000001; prioMret[4] = 1; prioCause[4] = 4'hB;
    prioSrc[5] = 6'b110000; prioMret[5] = 0; prioCause[5] = 4'h6;
    for (int i = 0; i < 6; i++) begin
      trapVector = 32'h0000_1000 + 32'(i * 16);
      mepc = 32'h4000_0000;
      {memoryStoreMisalign, memoryLoadMisalign, executeMisalign,
       decodeIllegal, decodeEbreak, decodeEcall} = prioSrc[i];
      mretRequest = prioMret[i];
      sb.push_back('{prioCause[i], 1'b0, 32'h0000_1000 + 32'(i * 16)});
      tick();
      clear_src();
      expect_trap($sformatf("prio%0d", i), 0);
      finish_redirect($sformatf("prio%0d", i), 1, 32'h0000_1000 + 32'(i * 16));
    end

    // Interrupt path
    trapVector = 32'h0000_0400;
    tc0 = dut.trapCount;
`ifdef TRAP_INTERRUPT_EN
    mie = 1;
    interrupt = 1;
    sb.push_back('{4'hB, 1'b1, 32'h0000_0400});
    tick();
    clear_src();
    expect_trap("irq", 2);
    finish_redirect("irq", 1, 32'h0000_0400);
    chk("irq_tc", dut.trapCount, tc0 + 1);
    tc0 = dut.trapCount;
`endif
    mie = 0;
    cr0 = crCount;
    interrupt = 1;
    tick(); tick();
    interrupt = 0;
    repeat (5) tick();
    chk("irq_masked_cr", crCount - cr0, 0);
    chk("irq_masked_stall", stall, 0);
    chk("irq_masked_tc", dut.trapCount, tc0);
`ifndef TRAP_INTERRUPT_EN
    mie = 1;
    interrupt = 1;
    repeat (5) tick();
    interrupt = 0;
    mie = 0;
    tick();
    chk("irq_off_cr", crCount - cr0, 0);
    chk("irq_off_mint", mcauseInterrupt, 0);
`endif

    // Reset in FLUSH aborts the trap
    trapVector = 32'h0000_0500;
    decodeIllegal = 1;
    tick();
    clear_src();
    chk("rflush_cr", controlReset, 1);
    reset = 0;
    #1;
    chk("rflush_stall", stall, 0);
    chk("rflush_cr0", controlReset, 0);
    chk("rflush_mcause", mcause, 0);
    chk("rflush_rv", redirectValid, 0);
    chk("rflush_pc", redirectPC, 0);
    chk("rflush_tc", dut.trapCount, 0);
    cr0 = crCount; rv0 = rvCount;
    #3;
    reset = 1;
    repeat (5) tick();
    chk("rflush_no_rv", rvCount - rv0, 0);
    chk("rflush_no_cr", crCount - cr0, 0);
    chk("rflush_sb", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have clock, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have reset, input, 1, asynchronous active-low reset; reset=0 forces reset state immediately.
REQ-003 SHALL have decodeIllegal, decodeEcall, decodeEbreak, input, 1 each, exception flags from the decode/execute register.
REQ-004 SHALL have executeMisalign, input, 1, instruction-address-misaligned flag from the execute/memory register.
REQ-005 SHALL have memoryLoadMisalign, memoryStoreMisalign, input, 1 each, flags from the memory/writeback register.
REQ-006 SHALL have mretRequest, input, 1, MRET in decode; mepc, input, 32, current MEPC CSR value.
REQ-007 SHALL have trapVector, input, 32, current MTVEC CSR value.
REQ-008 SHALL have interrupt, input, 1, external interrupt, asynchronous; mie, input, 1, MSTATUS.MIE.
REQ-009 SHALL have stall, output, 1, freezes all pipeline registers.
REQ-010 SHALL have controlReset, output, 1, one-cycle flush/trap-commit pulse to the CSR file and pipeline.
REQ-011 SHALL have mcause, output, 4, exception code valid while controlReset=1; mcauseInterrupt, output, 1, interrupt flag.
REQ-012 SHALL have redirectValid, output, 1, and redirectPC, output, 32, fetch redirect; redirectReady, input, 1, fetch acceptance.

Function
REQ-013 SHALL implement states IDLE, FLUSH, REDIRECT.
REQ-014 In IDLE, any pending source SHALL assert stall combinationally in the same cycle T, latch cause/target, and move to FLUSH at T+1.
REQ-015 Priority, highest first, SHALL be: memoryStoreMisalign (6), memoryLoadMisalign (4), executeMisalign (0), decodeIllegal (2), decodeEbreak (3), decodeEcall (B), interrupt, mretRequest.
REQ-016 FLUSH SHALL last exactly one cycle, with stall=1, controlReset=1, and the latched mcause/mcauseInterrupt; for an MRET, controlReset=1 and mcause=0.
REQ-017 REDIRECT SHALL assert redirectValid=1, stall=0, and redirectPC=trapVector latched at T for traps, or mepc latched at T for MRET.
REQ-018 REDIRECT SHALL hold redirectValid and redirectPC stable until the cycle redirectValid&&redirectReady, then return to IDLE.
REQ-019 All new sources arriving in FLUSH or REDIRECT SHALL be ignored; no queueing.
REQ-020 controlReset SHALL never be asserted on two consecutive cycles.
REQ-021 A 16-bit saturating trapCount SHALL increment on each FLUSH entry caused by a trap or interrupt, excluding MRET; it is internal and observable through the hierarchy.

Reset
REQ-022 On reset=0, the block SHALL enter IDLE and drive stall=0, controlReset=0, mcause=0, mcauseInterrupt=0, redirectValid=0, redirectPC=0, trapCount=0.
REQ-023 Reset asserted in FLUSH or REDIRECT SHALL abort the trap with no further controlReset or redirect.

Configuration
REQ-024 Macro TRAP_INTERRUPT_EN SHALL control the interrupt path.
- Defined: interrupt passes through a 2-flop synchronizer; the synchronized level AND mie is a source with mcause=B and mcauseInterrupt=1.
- Undefined: interrupt and mie are ignored and mcauseInterrupt is tied to 0.

Verification
REQ-025 Assert decodeIllegal for 1 cycle at T -> stall=1 at T; at T+1 controlReset=1, mcause=2; at T+2 redirectValid=1, redirectPC=trapVector (0x00000100).
REQ-026 Assert memoryStoreMisalign and decodeEcall together -> mcause=6 with exactly one controlReset pulse.
REQ-027 In REDIRECT, hold redirectReady=0 for 3 cycles and inject executeMisalign -> redirectPC is stable for 4 cycles, no second controlReset, return to IDLE after acceptance.
REQ-028 Assert mretRequest with mepc=0x80000040 -> controlReset pulses, trapCount is unchanged, redirectPC=0x80000040.
REQ-029 With TRAP_INTERRUPT_EN defined and mie=1, raise interrupt -> controlReset 3 cycles later with mcause=B, mcauseInterrupt=1; repeat with mie=0 -> no response.
REQ-030 Pull reset low during FLUSH -> all outputs go to 0 immediately; after release, no redirect occurs.
